// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-master data memory arbiter.
package data_mem_arb_pkg;

    // Arbiter ownership states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Master identifiers.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Number of byte lanes for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Avalon-MM style buses: one per requesting master, one towards the memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    import data_mem_arb_pkg::*;
    localparam int BE_W = be_width(DATA_W);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

interface data_mem_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    import data_mem_arb_pkg::*;
    localparam int BE_W = be_width(DATA_W);

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/data_mem_arbiter_rr_burst_arbiter.sv
// Two-requester round-robin arbiter with a bounded burst hold.
// The winner is combinational; ownership, burst count and last owner are registered.
module rr_burst_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       owner,
    output logic       granted
);
    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lst, lst_next;
    logic             win_valid;
    logic             win_id;

    // Winner selection: the owner keeps the bus until its burst is spent while the other waits.
    always_comb begin
        win_valid = 1'b0;
        win_id    = M0;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) begin
                    win_valid = 1'b1;
                    win_id    = ~lst;
                end else if (req[0]) begin
                    win_valid = 1'b1;
                    win_id    = M0;
                end else if (req[1]) begin
                    win_valid = 1'b1;
                    win_id    = M1;
                end else begin
                    win_valid = 1'b0;
                end
            end
            OWN0: begin
                if (req[0] && ((cnt < CNT_MAX) || !req[1])) begin
                    win_valid = 1'b1;
                    win_id    = M0;
                end else if (req[1]) begin
                    win_valid = 1'b1;
                    win_id    = M1;
                end else begin
                    win_valid = 1'b0;
                end
            end
            OWN1: begin
                if (req[1] && ((cnt < CNT_MAX) || !req[0])) begin
                    win_valid = 1'b1;
                    win_id    = M1;
                end else if (req[0]) begin
                    win_valid = 1'b1;
                    win_id    = M0;
                end else begin
                    win_valid = 1'b0;
                end
            end
            default: begin
                win_valid = 1'b0;
            end
        endcase
    end

    // Next ownership state: the burst count restarts whenever ownership changes hands.
    always_comb begin
        state_next = IDLE;
        cnt_next   = '0;
        lst_next   = lst;
        if (win_valid) begin
            state_next = win_id ? OWN1 : OWN0;
            lst_next   = win_id;
            if (state == (win_id ? OWN1 : OWN0)) begin
                cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end else begin
                cnt_next = CNT_W'(1);
            end
        end else begin
            state_next = IDLE;
        end
    end

    // Ownership register; after reset m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            lst   <= M1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lst   <= lst_next;
        end
    end

    assign granted = win_valid & ~reset;
    assign owner   = win_id;
    assign grant   = {granted & win_id, granted & ~win_id};

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between the NIOS data master (m0)
// and the NoC DMA (m1); steers 1-cycle-latency read data back to the issuer.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    data_mem_arbiter_if.slave m0,
    data_mem_arbiter_if.slave m1,
    data_mem_if.master        mem
);
    localparam int BE_W = be_width(DATA_W);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              owner;
    logic              granted;
    logic [ADDR_W-1:0] sel_address;
    logic [BE_W-1:0]   sel_byteenable;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_write;
    logic              rd_issue;
    logic              rd_pend;
    logic              rd_own;

    // A read together with a write counts as one request and is carried out as the write.
    assign req = {m1.read | m1.write, m0.read | m0.write};

    rr_burst_arbiter #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .grant   (grant),
        .owner   (owner),
        .granted (granted)
    );

    // Command mux: route the winning master's command to the memory port.
    always_comb begin
        sel_address    = m0.address;
        sel_byteenable = m0.byteenable;
        sel_writedata  = m0.writedata;
        sel_write      = m0.write;
        if (owner == M1) begin
            sel_address    = m1.address;
            sel_byteenable = m1.byteenable;
            sel_writedata  = m1.writedata;
            sel_write      = m1.write;
        end else begin
            sel_address    = m0.address;
            sel_byteenable = m0.byteenable;
            sel_writedata  = m0.writedata;
            sel_write      = m0.write;
        end
    end

    assign mem.address    = sel_address;
    assign mem.byteenable = sel_byteenable;
    assign mem.writedata  = sel_writedata;
    assign mem.write      = granted & sel_write;
    assign mem.chipselect = granted;
    assign mem.clken      = 1'b1;

    assign m0.waitrequest = reset | (req[0] & ~grant[0]);
    assign m1.waitrequest = reset | (req[1] & ~grant[1]);

    assign rd_issue = granted & ~sel_write;

    // Read-return pipeline: remember who issued the read granted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
            rd_own  <= M0;
        end else begin
            rd_pend <= rd_issue;
            rd_own  <= owner;
        end
    end

    // Reset also masks a pulse already in the pipeline so an in-flight read is dropped.
    assign m0.readdatavalid = rd_pend & (rd_own == M0) & ~reset;
    assign m1.readdatavalid = rd_pend & (rd_own == M1) & ~reset;
    assign m0.readdata      = mem.readdata;
    assign m1.readdata      = mem.readdata;

endmodule
